multi_pio: RTL

MULTI_PIO -- requirements
Module: multi_pio

---
 rtl/multi_pio.sv | 117 +++++++++++
 1 files changed

// File: rtl/multi_pio.sv
// rtl/multi_pio.sv - debounced multi-channel PIO with edge capture, irq and register port
module multi_pio #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EDGE_MODE       = 0
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   input  logic [2:0]       avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   output logic             avs_readdatavalid,
   input  logic [WIDTH-1:0] pio_in,
   output logic [WIDTH-1:0] pio_out,
   output logic             irq
);

   localparam logic [15:0] LP_CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_deb;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_edge;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_out;
   logic [15:0]      r_cnt [WIDTH];
   logic [31:0]      r_rdata;
   logic             r_rvalid;
   logic             r_irq;

   logic [WIDTH-1:0] w_wr_data;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] w_edge_det;
   logic [31:0]      w_rd_mux;
   logic             w_unused;

   assign w_wr_data = avs_writedata[WIDTH-1:0];
   assign w_unused  = ^avs_writedata;
   assign w_clr     = (avs_write && avs_address == 3'd3) ? w_wr_data : '0;

   always_comb begin
      w_edge_det = '0;
      case (EDGE_MODE)
         0:       w_edge_det = r_deb & ~r_prev;
         1:       w_edge_det = ~r_deb & r_prev;
         default: w_edge_det = (r_deb & ~r_prev) | (~r_deb & r_prev);
      endcase
   end

   // Read mux samples register state before any same-cycle write lands.
   always_comb begin
      w_rd_mux = '0;
      case (avs_address)
         3'd0:    w_rd_mux = 32'(r_deb);
         3'd1:    w_rd_mux = 32'(r_out);
         3'd2:    w_rd_mux = 32'(r_mask);
         3'd3:    w_rd_mux = 32'(r_edge);
         3'd6:    w_rd_mux = 32'(r_sync2);
         default: w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_deb    <= '0;
         r_prev   <= '0;
         r_edge   <= '0;
         r_mask   <= '0;
         r_out    <= '0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_irq    <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync1 <= pio_in;
         r_sync2 <= r_sync1;
         for (int i = 0; i < WIDTH; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == LP_CNT_MAX) begin
               r_deb[i] <= r_sync2[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 16'd1;
            end
         end
         r_prev <= r_deb;
         // A fresh edge is OR-ed in after the clear, so it survives a same-cycle W1C.
         r_edge <= (r_edge & ~w_clr) | w_edge_det;
         r_irq  <= |(r_edge & r_mask);
         if (avs_write) begin
            case (avs_address)
               3'd1:    r_out  <= w_wr_data;
               3'd2:    r_mask <= w_wr_data;
               3'd4:    r_out  <= r_out | w_wr_data;
               3'd5:    r_out  <= r_out & ~w_wr_data;
               default: ;
            endcase
         end
         r_rvalid <= avs_read;
         r_rdata  <= avs_read ? w_rd_mux : '0;
      end
   end

   assign avs_readdata      = r_rdata;
   assign avs_readdatavalid = r_rvalid;
   assign pio_out           = r_out;
   assign irq               = r_irq;

endmodule
